// File: rtl/vlsu_pkg.sv
// Shared types and constants for the VLSU meta generator.
// Contents:
//   - datapath geometry: NrLanes, VLEN, ALEN, AxiDataWidth, BeatBytes
//   - AXI burst limits: MaxBurstBeats (256 beats), PageBytes (4 KiB)
//   - meta_glb_t   : per-request meta (isLoad, rmnSeg, rmnGrp)
//   - meta_seglv_t : per-burst meta (segBaseAddr, txnCnt, txnNum, beatLen, ltN)
//   - meta_state_e : generator FSM state encoding
package vlsu_pkg;

   localparam int unsigned NrLanes       = 4;
   localparam int unsigned VLEN          = 4096;
   localparam int unsigned ALEN          = 32;
   localparam int unsigned AxiDataWidth  = 64;
   localparam int unsigned BeatBytes     = AxiDataWidth / 8;
   localparam int unsigned BeatOffW      = $clog2(BeatBytes);
   localparam int unsigned MaxBurstBeats = 256;
   localparam int unsigned PageBytes     = 4096;
   localparam int unsigned SegBytesW     = $clog2(VLEN) + 1;
   localparam int unsigned TxnCntW       = 8;
   localparam int unsigned BeatLenW      = 8;
   localparam int unsigned LtNW          = BeatOffW + 1;

   typedef logic [$clog2(NrLanes)-1:0] lane_id_t;

   typedef struct packed {
      logic       isLoad;
      logic [2:0] rmnSeg;
      logic [2:0] rmnGrp;
   } meta_glb_t;

   typedef struct packed {
      logic [ALEN-1:0]     segBaseAddr;
      logic [TxnCntW-1:0]  txnCnt;
      logic [TxnCntW-1:0]  txnNum;
      logic [BeatLenW-1:0] beatLen;
      logic [LtNW-1:0]     ltN;
   } meta_seglv_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      EMIT = 2'd2
   } meta_state_e;

endpackage

// File: rtl/vlsu_burst_calc.sv
// Combinational sizing of the next AXI INCR burst of a segment.
// Ports:
//   cur_addr_i   : byte address where the burst starts
//   seg_rmn_i    : bytes still to transfer in the current segment (>= 1)
//   txn_bytes_o  : bytes covered by this burst
//   beat_len_o   : AXI len (beats - 1)
//   lt_n_o       : valid bytes in the final beat (1..BeatBytes)
//   last_o       : this burst finishes the segment
// All arithmetic is one bit wider than the address so the page/burst room
// terms never truncate.
module vlsu_burst_calc
   import vlsu_pkg::*;
(
   input  logic [ALEN-1:0]      cur_addr_i,
   input  logic [SegBytesW-1:0] seg_rmn_i,
   output logic [SegBytesW-1:0] txn_bytes_o,
   output logic [BeatLenW-1:0]  beat_len_o,
   output logic [LtNW-1:0]      lt_n_o,
   output logic                 last_o
);

   localparam int unsigned WW = ALEN + 1;

   logic [WW-1:0] addr_w;
   logic [WW-1:0] beat_off;
   logic [WW-1:0] page_room;
   logic [WW-1:0] burst_room;
   logic [WW-1:0] rmn_w;
   logic [WW-1:0] min_a;
   logic [WW-1:0] txn;
   logic [WW-1:0] beat_end;
   logic [WW-1:0] end_off;

   always_comb begin
      addr_w     = WW'(cur_addr_i);
      beat_off   = addr_w & WW'(BeatBytes - 1);
      page_room  = WW'(PageBytes) - (addr_w & WW'(PageBytes - 1));
      // An unaligned start eats into the 256-beat budget of the first beat.
      burst_room = WW'(MaxBurstBeats * BeatBytes) - beat_off;
      rmn_w      = WW'(seg_rmn_i);
      min_a      = (rmn_w < page_room) ? rmn_w : page_room;
      txn        = (min_a < burst_room) ? min_a : burst_room;
      // Round the covered span up to whole beats.
      beat_end   = (beat_off + txn + WW'(BeatBytes - 1)) >> BeatOffW;
      end_off    = (beat_off + txn - WW'(1)) & WW'(BeatBytes - 1);

      txn_bytes_o = SegBytesW'(txn);
      beat_len_o  = BeatLenW'(beat_end - WW'(1));
      lt_n_o      = LtNW'(end_off) + LtNW'(1);
      last_o      = (rmn_w == txn);
   end

endmodule

// File: rtl/vlsu_meta_gen.sv
// VLSU meta generator: walks groups and segments of one vector load/store
// request and emits one (meta_glb_t, meta_seglv_t) pair per AXI INCR burst.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   req_*                  : request handshake and fields (accepted in IDLE)
//   meta_valid_o/ready_i   : meta handshake, outputs held while stalled
//   meta_glb_o/seglv_o     : meta pair for the current burst
//   busy_o                 : FSM not in IDLE
// Optional build macro VLSU_META_GEN_PERF_EN adds saturating counters
//   perf_txn_cnt_o (meta handshakes) and perf_stall_cnt_o (stalled cycles).
module vlsu_meta_gen
   import vlsu_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [ALEN-1:0]      req_addr_i,
   input  logic                 req_is_load_i,
   input  logic [2:0]           req_nf_i,
   input  logic [2:0]           req_ngrp_i,
   input  logic [ALEN-1:0]      req_seg_stride_i,
   input  logic [ALEN-1:0]      req_grp_stride_i,
   input  logic [SegBytesW-1:0] req_seg_bytes_i,
   output logic                 meta_valid_o,
   input  logic                 meta_ready_i,
   output meta_glb_t            meta_glb_o,
   output meta_seglv_t          meta_seglv_o,
   output logic                 busy_o
`ifdef VLSU_META_GEN_PERF_EN
   ,
   output logic [31:0]          perf_txn_cnt_o,
   output logic [31:0]          perf_stall_cnt_o
`endif
);

   meta_state_e          state_reg, state_next;
   logic [ALEN-1:0]      cur_addr_reg, cur_addr_next;
   logic [ALEN-1:0]      seg_base_reg, seg_base_next;
   logic [ALEN-1:0]      grp_base_reg, grp_base_next;
   logic [ALEN-1:0]      seg_stride_reg, seg_stride_next;
   logic [ALEN-1:0]      grp_stride_reg, grp_stride_next;
   logic [SegBytesW-1:0] seg_bytes_reg, seg_bytes_next;
   logic [SegBytesW-1:0] seg_rmn_reg, seg_rmn_next;
   logic [SegBytesW-1:0] txn_bytes_reg, txn_bytes_next;
   logic [2:0]           nf_reg, nf_next, ngrp_reg, ngrp_next;
   logic [2:0]           seg_reg, seg_next, grp_reg, grp_next;
   logic [TxnCntW-1:0]   txn_cnt_reg, txn_cnt_next;
   logic                 is_load_reg, is_load_next;
   logic                 last_reg, last_next;
   meta_glb_t            glb_reg, glb_next;
   meta_seglv_t          seglv_reg, seglv_next;

   logic [SegBytesW-1:0] calc_txn_bytes;
   logic [BeatLenW-1:0]  calc_beat_len;
   logic [LtNW-1:0]      calc_lt_n;
   logic                 calc_last;

   vlsu_burst_calc u_burst_calc (
      .cur_addr_i  (cur_addr_reg),
      .seg_rmn_i   (seg_rmn_reg),
      .txn_bytes_o (calc_txn_bytes),
      .beat_len_o  (calc_beat_len),
      .lt_n_o      (calc_lt_n),
      .last_o      (calc_last)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= IDLE;
         cur_addr_reg   <= '0;
         seg_base_reg   <= '0;
         grp_base_reg   <= '0;
         seg_stride_reg <= '0;
         grp_stride_reg <= '0;
         seg_bytes_reg  <= '0;
         seg_rmn_reg    <= '0;
         txn_bytes_reg  <= '0;
         nf_reg         <= '0;
         ngrp_reg       <= '0;
         seg_reg        <= '0;
         grp_reg        <= '0;
         txn_cnt_reg    <= '0;
         is_load_reg    <= 1'b0;
         last_reg       <= 1'b0;
         glb_reg        <= '0;
         seglv_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         cur_addr_reg   <= cur_addr_next;
         seg_base_reg   <= seg_base_next;
         grp_base_reg   <= grp_base_next;
         seg_stride_reg <= seg_stride_next;
         grp_stride_reg <= grp_stride_next;
         seg_bytes_reg  <= seg_bytes_next;
         seg_rmn_reg    <= seg_rmn_next;
         txn_bytes_reg  <= txn_bytes_next;
         nf_reg         <= nf_next;
         ngrp_reg       <= ngrp_next;
         seg_reg        <= seg_next;
         grp_reg        <= grp_next;
         txn_cnt_reg    <= txn_cnt_next;
         is_load_reg    <= is_load_next;
         last_reg       <= last_next;
         glb_reg        <= glb_next;
         seglv_reg      <= seglv_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cur_addr_next   = cur_addr_reg;
      seg_base_next   = seg_base_reg;
      grp_base_next   = grp_base_reg;
      seg_stride_next = seg_stride_reg;
      grp_stride_next = grp_stride_reg;
      seg_bytes_next  = seg_bytes_reg;
      seg_rmn_next    = seg_rmn_reg;
      txn_bytes_next  = txn_bytes_reg;
      nf_next         = nf_reg;
      ngrp_next       = ngrp_reg;
      seg_next        = seg_reg;
      grp_next        = grp_reg;
      txn_cnt_next    = txn_cnt_reg;
      is_load_next    = is_load_reg;
      last_next       = last_reg;
      glb_next        = glb_reg;
      seglv_next      = seglv_reg;

      case (state_reg)
         IDLE: begin
            if (req_valid_i) begin
               is_load_next    = req_is_load_i;
               nf_next         = req_nf_i;
               ngrp_next       = req_ngrp_i;
               seg_stride_next = req_seg_stride_i;
               grp_stride_next = req_grp_stride_i;
               seg_bytes_next  = req_seg_bytes_i;
               seg_rmn_next    = req_seg_bytes_i;
               cur_addr_next   = req_addr_i;
               seg_base_next   = req_addr_i;
               grp_base_next   = req_addr_i;
               seg_next        = '0;
               grp_next        = '0;
               txn_cnt_next    = '0;
               state_next      = CALC;
            end
         end
         CALC: begin
            txn_bytes_next         = calc_txn_bytes;
            last_next              = calc_last;
            glb_next.isLoad        = is_load_reg;
            glb_next.rmnSeg        = nf_reg - seg_reg;
            glb_next.rmnGrp        = ngrp_reg - grp_reg;
            seglv_next.segBaseAddr = cur_addr_reg;
            seglv_next.txnCnt      = txn_cnt_reg;
            // Only the last burst of a segment reports its true final index.
            seglv_next.txnNum      = calc_last ? txn_cnt_reg : txn_cnt_reg + TxnCntW'(1);
            seglv_next.beatLen     = calc_beat_len;
            seglv_next.ltN         = calc_lt_n;
            state_next             = EMIT;
         end
         EMIT: begin
            if (meta_ready_i) begin
               state_next = CALC;
               if (!last_reg) begin
                  cur_addr_next = cur_addr_reg + ALEN'(txn_bytes_reg);
                  seg_rmn_next  = seg_rmn_reg - txn_bytes_reg;
                  txn_cnt_next  = txn_cnt_reg + TxnCntW'(1);
               end else if (seg_reg < nf_reg) begin
                  // Segment bases accumulate the stride, avoiding a multiplier.
                  seg_next      = seg_reg + 3'd1;
                  txn_cnt_next  = '0;
                  seg_base_next = seg_base_reg + seg_stride_reg;
                  cur_addr_next = seg_base_reg + seg_stride_reg;
                  seg_rmn_next  = seg_bytes_reg;
               end else if (grp_reg < ngrp_reg) begin
                  grp_next      = grp_reg + 3'd1;
                  seg_next      = '0;
                  txn_cnt_next  = '0;
                  grp_base_next = grp_base_reg + grp_stride_reg;
                  seg_base_next = grp_base_reg + grp_stride_reg;
                  cur_addr_next = grp_base_reg + grp_stride_reg;
                  seg_rmn_next  = seg_bytes_reg;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign req_ready_o  = (state_reg == IDLE);
   assign meta_valid_o = (state_reg == EMIT);
   assign busy_o       = (state_reg != IDLE);
   assign meta_glb_o   = glb_reg;
   assign meta_seglv_o = seglv_reg;

`ifdef VLSU_META_GEN_PERF_EN
   logic [31:0] perf_txn_reg, perf_stall_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_txn_reg   <= '0;
         perf_stall_reg <= '0;
      end else begin
         if (meta_valid_o && meta_ready_i && !(&perf_txn_reg)) begin
            perf_txn_reg <= perf_txn_reg + 32'd1;
         end
         if (meta_valid_o && !meta_ready_i && !(&perf_stall_reg)) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
      end
   end

   assign perf_txn_cnt_o   = perf_txn_reg;
   assign perf_stall_cnt_o = perf_stall_reg;
`endif

   a_seg_bytes_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i && req_ready_o) |-> (req_seg_bytes_i != '0));

   a_meta_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (meta_valid_o && !meta_ready_i) |=>
         (meta_valid_o && $stable(meta_glb_o) && $stable(meta_seglv_o)));

endmodule
